watch_wb_regs: RTL and testbench

Wishbone classic slave for the Caravel user area that completes the bus handshake for the watch and gives firmware a read path. Decodes a register window and acknowledges every hit within one cycle. Latches the 12-bit counter preset and pulses it to the watch core, returns the live HH:MM digits on read, and raises an interrupt on each minute change. Sits between the Wishbone slave ports of the user-project wrapper and the watch core.

---
 rtl/watch_wb_regs.sv | 145 ++++++++++++++
 tb/tb_watch_wb_regs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/watch_wb_regs.sv
// Wishbone classic register slave for the watch core: CFG preset/load strobe, live TIME readback,
// and (when WATCH_WB_IRQ_EN is defined) a minute-tick interrupt with W1C status and enable.
`timescale 1ns/1ps

module watch_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [11:0] cfg_o,
    output logic        cfg_valid_o,
    input  logic [15:0] time_i,
    output logic        irq_o
);

    typedef enum logic {IDLE, ACK} state_e;

    state_e      state_q, state_d;
    logic        hit, accept, cfgWrite;
    logic [5:0]  regSel;
    logic [31:0] rdMux, rdData_d, rdData_q;
    logic [11:0] cfg_d, cfg_q;
    logic        cfgValid_q;
    logic        unusedBits;

`ifdef WATCH_WB_IRQ_EN
    logic        primed_q;
    logic [3:0]  prevUnits_q;
    logic        irqStatus_d, irqStatus_q;
    logic        irqEnable_d, irqEnable_q;
    logic        irq_q;
    logic        tick, statusClear, enableWrite;
`endif

    assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign accept   = (state_q == IDLE) & hit;
    assign regSel   = wbs_adr_i[7:2];
    assign cfgWrite = accept & wbs_we_i & (regSel == 6'd0) & (wbs_sel_i[0] | wbs_sel_i[1]);

    assign unusedBits = ^{wbs_adr_i[1:0], wbs_dat_i[31:12], wbs_sel_i[3:2]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACK always returns to IDLE, so a held strobe yields at most one ack every two cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state_q == ACK);
    end

    always_comb begin
        rdMux = 32'h0;
        case (regSel)
            6'd0: rdMux = {20'h0, cfg_q};
            6'd1: rdMux = {16'h0, time_i};
`ifdef WATCH_WB_IRQ_EN
            6'd2: rdMux = {31'h0, irqStatus_q};
            6'd3: rdMux = {31'h0, irqEnable_q};
`endif
            default: rdMux = 32'h0;
        endcase
        rdData_d = (accept & ~wbs_we_i) ? rdMux : 32'h0;
    end

    always_comb begin
        cfg_d = cfg_q;
        if (cfgWrite) begin
            if (wbs_sel_i[0]) cfg_d[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) cfg_d[11:8] = wbs_dat_i[11:8];
        end
    end

    // Read data is captured at the accept edge, so it is valid exactly in the ack cycle and zero otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rdData_q   <= 32'h0;
            cfg_q      <= 12'h0;
            cfgValid_q <= 1'b0;
        end else begin
            rdData_q   <= rdData_d;
            cfg_q      <= cfg_d;
            cfgValid_q <= cfgWrite;
        end
    end

    assign wbs_dat_o   = rdData_q;
    assign cfg_o       = cfg_q;
    assign cfg_valid_o = cfgValid_q;

`ifdef WATCH_WB_IRQ_EN
    assign tick        = primed_q & (time_i[3:0] != prevUnits_q);
    assign statusClear = accept & wbs_we_i & (regSel == 6'd2) & wbs_sel_i[0] & wbs_dat_i[0];
    assign enableWrite = accept & wbs_we_i & (regSel == 6'd3) & wbs_sel_i[0];

    // A tick arriving together with a W1C clear takes priority.
    always_comb begin
        irqStatus_d = irqStatus_q;
        if (statusClear) irqStatus_d = 1'b0;
        if (tick)        irqStatus_d = 1'b1;
        irqEnable_d = enableWrite ? wbs_dat_i[0] : irqEnable_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            primed_q    <= 1'b0;
            prevUnits_q <= 4'h0;
            irqStatus_q <= 1'b0;
            irqEnable_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            primed_q    <= 1'b1;
            prevUnits_q <= time_i[3:0];
            irqStatus_q <= irqStatus_d;
            irqEnable_q <= irqEnable_d;
            irq_q       <= irqStatus_q & irqEnable_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_watch_wb_regs.sv
// Directed scoreboard bench for watch_wb_regs; expectations adapt to whether WATCH_WB_IRQ_EN is defined.
`timescale 1ns/1ps

module tb_watch_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, weI;
    logic [3:0]  sel;
    logic [31:0] adr, datI;
    logic        ackO;
    logic [31:0] datO;
    logic [11:0] cfgO;
    logic        cfgValidO;
    logic [15:0] timeI;
    logic        irqO;

    int          testCount = 0;
    int          failCount = 0;
    logic [31:0] expQ[$];

    watch_wb_regs #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (weI),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (datI),
        .wbs_ack_o   (ackO),
        .wbs_dat_o   (datO),
        .cfg_o       (cfgO),
        .cfg_valid_o (cfgValidO),
        .time_i      (timeI),
        .irq_o       (irqO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives a request (caller is at a negedge), waits a bounded time for ack and scores the read data.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [31:0] expData);
        logic [31:0] e;
        bit          gotAck;
        expQ.push_back(expData);
        cyc = 1'b1; stb = 1'b1; weI = we; adr = a; sel = s; datI = d;
        gotAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ackO === 1'b1) begin
                gotAck = 1'b1;
                break;
            end
        end
        if (gotAck) begin
            e = expQ.pop_front();
            checkOutput({tag, "_data"}, datO, e);
        end else begin
            checkOutput({tag, "_ack"}, {31'h0, ackO}, 32'h1);
        end
    endtask

    task automatic busIdle();
        cyc = 1'b0; stb = 1'b0; weI = 1'b0; adr = 32'h0; sel = 4'h0; datI = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; weI = 1'b0; adr = 32'h0; sel = 4'h0; datI = 32'h0;
        timeI = 16'h1259;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstAck", {31'h0, ackO}, 32'h0);
        checkOutput("rstDat", datO, 32'h0);
        checkOutput("rstCfg", {20'h0, cfgO}, 32'h0);
        checkOutput("rstCfgValid", {31'h0, cfgValidO}, 32'h0);
        checkOutput("rstIrq", {31'h0, irqO}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Full-lane CFG write: update and pulse in the ack cycle only.
        applyStimulus("cfgWr", 1'b1, BASE + 32'h00, 4'hF, 32'h0000_0ABC, 32'h0);
        checkOutput("cfgWrCfg", {20'h0, cfgO}, 32'h0000_0ABC);
        checkOutput("cfgWrValid", {31'h0, cfgValidO}, 32'h1);
        busIdle();
        checkOutput("cfgWrValidAfter", {31'h0, cfgValidO}, 32'h0);
        checkOutput("cfgWrAckAfter", {31'h0, ackO}, 32'h0);
        applyStimulus("cfgRd", 1'b0, BASE + 32'h00, 4'hF, 32'h0, 32'h0000_0ABC);
        busIdle();

        // Upper lanes only: acked, no update, no pulse.
        applyStimulus("cfgWrHi", 1'b1, BASE + 32'h00, 4'hC, 32'h0000_0123, 32'h0);
        checkOutput("cfgWrHiCfg", {20'h0, cfgO}, 32'h0000_0ABC);
        checkOutput("cfgWrHiValid", {31'h0, cfgValidO}, 32'h0);
        busIdle();

        applyStimulus("timeRd", 1'b0, BASE + 32'h04, 4'hF, 32'h0, 32'h0000_1259);
        busIdle();
        checkOutput("timeRdAfter", datO, 32'h0);

`ifdef WATCH_WB_IRQ_EN
        applyStimulus("enWr", 1'b1, BASE + 32'h0C, 4'hF, 32'h1, 32'h0);
        busIdle();
        applyStimulus("enRd", 1'b0, BASE + 32'h0C, 4'hF, 32'h0, 32'h1);
        busIdle();
        applyStimulus("statRd0", 1'b0, BASE + 32'h08, 4'hF, 32'h0, 32'h0);
        busIdle();
        timeI = 16'h1300;
        @(negedge clk);
        checkOutput("irqLag", {31'h0, irqO}, 32'h0);
        @(negedge clk);
        checkOutput("irqSet", {31'h0, irqO}, 32'h1);
        applyStimulus("statRd1", 1'b0, BASE + 32'h08, 4'hF, 32'h0, 32'h1);
        busIdle();
        applyStimulus("w1c", 1'b1, BASE + 32'h08, 4'hF, 32'h1, 32'h0);
        busIdle();
        checkOutput("irqCleared", {31'h0, irqO}, 32'h0);
        timeI = 16'h1301;
        @(negedge clk);
        @(negedge clk);
        checkOutput("irqSet2", {31'h0, irqO}, 32'h1);
        timeI = 16'h1302;
        applyStimulus("w1cTick", 1'b1, BASE + 32'h08, 4'hF, 32'h1, 32'h0);
        busIdle();
        applyStimulus("statTickWins", 1'b0, BASE + 32'h08, 4'hF, 32'h0, 32'h1);
        busIdle();
        checkOutput("irqTickWins", {31'h0, irqO}, 32'h1);
`else
        applyStimulus("enWrOff", 1'b1, BASE + 32'h0C, 4'hF, 32'h1, 32'h0);
        busIdle();
        timeI = 16'h1300;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("irqOff", {31'h0, irqO}, 32'h0);
        applyStimulus("statRdOff", 1'b0, BASE + 32'h08, 4'hF, 32'h0, 32'h0);
        busIdle();
        applyStimulus("enRdOff", 1'b0, BASE + 32'h0C, 4'hF, 32'h0, 32'h0);
        busIdle();
        checkOutput("irqOff2", {31'h0, irqO}, 32'h0);
`endif

        // Address outside the window must never be acked.
        cyc = 1'b1; stb = 1'b1; weI = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ackO === 1'b1) acks++;
        end
        checkOutput("missNoAck", acks, 0);
        busIdle();

        applyStimulus("unmappedRd", 1'b0, BASE + 32'h40, 4'hF, 32'h0, 32'h0);
        busIdle();

        // Strobe held for six cycles: three acks, each carrying CFG.
        for (int i = 0; i < 3; i++) expQ.push_back(32'h0000_0ABC);
        cyc = 1'b1; stb = 1'b1; weI = 1'b0; adr = BASE; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ackO === 1'b1) begin
                acks++;
                if (expQ.size() > 0) checkOutput("b2bData", datO, expQ.pop_front());
            end
        end
        checkOutput("b2bAcks", acks, 3);
        busIdle();

        // Reset landing in the ack cycle of a CFG write.
        cyc = 1'b1; stb = 1'b1; weI = 1'b1; adr = BASE; sel = 4'hF; datI = 32'h0000_05A5;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRstAck", {31'h0, ackO}, 32'h0);
        checkOutput("midRstValid", {31'h0, cfgValidO}, 32'h0);
        checkOutput("midRstCfg", {20'h0, cfgO}, 32'h0);
        checkOutput("midRstIrq", {31'h0, irqO}, 32'h0);
        busIdle();
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("postRstCfgRd", 1'b0, BASE, 4'hF, 32'h0, 32'h0);
        busIdle();

        checkOutput("sbEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
